// File: rtl/cmos_capture_packer.sv
// CMOS sensor capture stage: registers the sensor pins, skips settling frames,
// packs byte pairs into RGB565 pixels and enforces line/frame geometry.
module cmos_capture_packer #(
    parameter int unsigned H_PIX       = 1024,
    parameter int unsigned V_LINES     = 720,
    parameter int unsigned SKIP_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        cmos_vsyn,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        capture_en,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        line_err,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned PW = $clog2(H_PIX + 1);
    localparam int unsigned LW = $clog2(V_LINES + 1);
    localparam int unsigned SW = 4;

    localparam logic [PW-1:0] PIX_LAST = PW'(H_PIX - 1);
    localparam logic [PW-1:0] PIX_FULL = PW'(H_PIX);
    localparam logic [LW-1:0] LINE_MAX = LW'(V_LINES);
    localparam logic [SW-1:0] SKIP_RLD = SW'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_SKIP   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_s_vs;
    logic            r_s_hr;
    logic [7:0]      r_s_d;
    logic            r_vs_d;
    logic            r_line_d;

    logic [SW-1:0]   r_skip;
    logic [PW-1:0]   r_pix_cnt;
    logic [LW-1:0]   r_line_cnt;
    logic            r_phase;
    logic [7:0]      r_hi;
    logic            r_sof_arm;

    logic            r_p_v;
    logic [15:0]     r_p_d;
    logic            r_p_sof;
    logic            r_p_eol;

    logic            w_vs_rise;
    logic            w_vs_fall;
    logic            w_line_on;
    logic            w_line_fall;
    logic            w_start_frame;
    logic            w_end_frame;
    logic            w_skip_dec;
    logic            w_active;
    logic            w_line_ok;
    logic            w_pack;
    logic            w_pair;
    logic            w_room;
    logic            w_emit;
    logic            w_drop;
    logic            w_close;
    logic            w_bad_close;

    // Sync/line edge detection on the registered pins; href is ignored during vblank
    assign w_vs_rise   = r_s_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_s_vs & r_vs_d;
    assign w_line_on   = r_s_hr & ~r_s_vs;
    assign w_line_fall = r_line_d & ~w_line_on;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_line_ok   = (r_line_cnt < LINE_MAX);
    assign w_pack      = w_active & w_line_on & w_line_ok;
    assign w_pair      = w_pack & r_phase;
    assign w_room      = (r_pix_cnt < PIX_FULL);
    assign w_emit      = w_pair & w_room;
    assign w_drop      = w_pair & ~w_room;
    assign w_close     = w_active & w_line_fall & w_line_ok;
    assign w_bad_close = w_close & ((r_pix_cnt != PIX_FULL) | r_phase);

    // Input stage: single register on all sensor pins
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_s_vs   <= 1'b0;
            r_s_hr   <= 1'b0;
            r_s_d    <= 8'd0;
            r_vs_d   <= 1'b0;
            r_line_d <= 1'b0;
        end else begin
            r_s_vs   <= cmos_vsyn;
            r_s_hr   <= cmos_href;
            r_s_d    <= cmos_data;
            r_vs_d   <= r_s_vs;
            r_line_d <= w_line_on;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: capture only ever begins on a full vsync high->low
    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_end_frame   = 1'b0;
        w_skip_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (capture_en && r_s_vs) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_vs_fall) begin
                    if (r_skip != '0) begin
                        w_state_nxt = ST_SKIP;
                        w_skip_dec  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_ACTIVE;
                        w_start_frame = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_end_frame = 1'b1;
                    w_state_nxt = capture_en ? ST_SYNC : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Settling-frame counter, reloaded whenever capture is idle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_skip <= SKIP_RLD;
        end else if (r_state == ST_IDLE) begin
            r_skip <= SKIP_RLD;
        end else if (w_skip_dec) begin
            r_skip <= r_skip - SW'(1);
        end
    end

    // Byte phase, pixel and line counters
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_phase    <= 1'b0;
            r_hi       <= 8'd0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_start_frame) begin
            r_phase    <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else if (w_line_fall) begin
            r_phase   <= 1'b0;
            r_pix_cnt <= '0;
            if (w_active && w_line_ok) begin
                r_line_cnt <= r_line_cnt + LW'(1);
            end
        end else if (w_pack) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_hi <= r_s_d;
            end else if (w_room) begin
                r_pix_cnt <= r_pix_cnt + PW'(1);
            end
        end
    end

    // Pixel formation stage with its frame/line marks
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_p_v     <= 1'b0;
            r_p_d     <= 16'd0;
            r_p_sof   <= 1'b0;
            r_p_eol   <= 1'b0;
            r_sof_arm <= 1'b0;
        end else begin
            r_p_v   <= w_emit;
            r_p_sof <= w_emit & r_sof_arm;
            r_p_eol <= w_emit & (r_pix_cnt == PIX_LAST);
            if (w_emit) begin
                r_p_d <= {r_hi, r_s_d};
            end
            if (w_start_frame) begin
                r_sof_arm <= 1'b1;
            end else if (w_emit) begin
                r_sof_arm <= 1'b0;
            end
        end
    end

    // Output pixel register; data holds between strobes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pix_valid <= 1'b0;
            pix_data  <= 16'd0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else begin
            pix_valid <= r_p_v;
            pix_sof   <= r_p_sof;
            pix_eol   <= r_p_eol;
            if (r_p_v) begin
                pix_data <= r_p_d;
            end
        end
    end

    // Frame status: done pulse, captured-frame count, sticky line error
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= w_end_frame;
            if (w_end_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (w_start_frame) begin
                line_err <= 1'b0;
            end else if (w_drop || w_bad_close) begin
                line_err <= 1'b1;
            end
        end
    end

endmodule
